// File: rtl/str_seq_engine.sv
// str_seq_engine: byte-serial string engine, right-justified packing; `STR_SEQ_CASE_EN adds TOUPPER/TOLOWER.
// Latency 1 cycle (CMP/REP/CASE: one char per cycle +1); cmd_ready low until after rsp_valid, busy cmds dropped.
module str_seq_engine #(
  parameter int MAX_CHARS = 8,
  parameter int IDXW      = $clog2(MAX_CHARS),
  parameter int CNTW      = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cmd_valid,
  output logic                   cmd_ready,
  input  logic [2:0]             cmd_op,
  input  logic [IDXW-1:0]        cmd_idx,
  input  logic [7:0]             cmd_char,
  input  logic [CNTW-1:0]        cmd_count,
  input  logic [MAX_CHARS*8-1:0] cmp_str,
  input  logic [IDXW:0]          cmp_len,
  output logic                   rsp_valid,
  output logic                   rsp_err,
  output logic [7:0]             rsp_char,
  output logic [1:0]             rsp_cmp,
  output logic [MAX_CHARS*8-1:0] str_out,
  output logic [IDXW:0]          str_len,
  output logic                   overflow
);

  localparam int SW = MAX_CHARS * 8;
  localparam int LW = IDXW + 1;
  localparam int TW = CNTW + LW;
  localparam logic [LW-1:0] MAXL = LW'(MAX_CHARS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_RSP,
    S_CMP,
    S_REP
`ifdef STR_SEQ_CASE_EN
    , S_CASE
`endif
  } state_t;

  state_t          state;
  logic [LW-1:0]   cur;
  logic [SW-1:0]   cstr;
  logic [LW-1:0]   clen;
  logic [LW-1:0]   rlen;
  logic [TW-1:0]   rtgt;
`ifdef STR_SEQ_CASE_EN
  logic            case_up;
`endif

  logic [LW-1:0]   clamp_len;
  logic [LW-1:0]   cmp_min;
  logic [7:0]      cur_ch;
  logic [7:0]      opd_ch;

  // Character i lives in byte (len-1-i).
  function automatic logic [7:0] char_at(input logic [SW-1:0] s, input logic [LW-1:0] len,
                                         input logic [LW-1:0] i);
    logic [LW-1:0] pos;
    pos = len - i - LW'(1);
    return 8'(s >> {pos, 3'b000});
  endfunction

  function automatic logic [SW-1:0] put_char(input logic [SW-1:0] s, input logic [LW-1:0] len,
                                             input logic [LW-1:0] i, input logic [7:0] c);
    logic [LW-1:0] pos;
    pos = len - i - LW'(1);
    return (s & ~(SW'(8'hFF) << {pos, 3'b000})) | (SW'(c) << {pos, 3'b000});
  endfunction

  function automatic logic [1:0] len_order(input logic [LW-1:0] a, input logic [LW-1:0] b);
    if (a == b)     return 2'b00;
    else if (a < b) return 2'b01;
    else            return 2'b10;
  endfunction

`ifdef STR_SEQ_CASE_EN
  function automatic logic [7:0] conv_case(input logic [7:0] c, input logic up);
    if (up && c >= 8'h61 && c <= 8'h7A)       return c - 8'h20;
    else if (!up && c >= 8'h41 && c <= 8'h5A) return c + 8'h20;
    else                                      return c;
  endfunction
`endif

  assign clamp_len = (cmp_len > MAXL) ? MAXL : cmp_len;
  assign cmp_min   = (str_len < clen) ? str_len : clen;
  assign cur_ch    = char_at(str_out, str_len, cur);
  assign opd_ch    = char_at(cstr, clen, cur);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cmd_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_char  <= 8'd0;
      rsp_cmp   <= 2'b00;
      str_out   <= '0;
      str_len   <= '0;
      overflow  <= 1'b0;
      cur       <= '0;
      cstr      <= '0;
      clen      <= '0;
      rlen      <= '0;
      rtgt      <= '0;
`ifdef STR_SEQ_CASE_EN
      case_up   <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_valid) begin
            // Default: single-cycle op answered next cycle; multi-cycle ops clear rsp_valid below.
            cmd_ready <= 1'b0;
            rsp_valid <= 1'b1;
            rsp_err   <= 1'b0;
            state     <= S_RSP;
            cur       <= '0;
            case (cmd_op)
              3'd0: begin
                str_out  <= '0;
                str_len  <= '0;
                overflow <= 1'b0;
              end
              3'd1: begin
                if (str_len == MAXL) begin
                  overflow <= 1'b1;
                  rsp_err  <= 1'b1;
                end else begin
                  str_out <= {str_out[SW-9:0], cmd_char};
                  str_len <= str_len + LW'(1);
                end
              end
              3'd2: begin
                if (LW'(cmd_idx) >= str_len || cmd_char == 8'd0) rsp_err <= 1'b1;
                else str_out <= put_char(str_out, str_len, LW'(cmd_idx), cmd_char);
              end
              3'd3: begin
                if (LW'(cmd_idx) >= str_len) begin
                  rsp_char <= 8'd0;
                  rsp_err  <= 1'b1;
                end else begin
                  rsp_char <= char_at(str_out, str_len, LW'(cmd_idx));
                end
              end
              3'd4: begin
                cstr <= cmp_str;
                clen <= clamp_len;
                if (str_len == '0 || clamp_len == '0) begin
                  rsp_cmp <= len_order(str_len, clamp_len);
                end else begin
                  state     <= S_CMP;
                  rsp_valid <= 1'b0;
                end
              end
              3'd5: begin
                rlen <= str_len;
                rtgt <= TW'(cmd_count) * TW'(str_len);
                if (cmd_count == '0) begin
                  str_out <= '0;
                  str_len <= '0;
                end else if (cmd_count != CNTW'(1) && str_len != '0) begin
                  state     <= S_REP;
                  rsp_valid <= 1'b0;
                end
              end
              default: begin
`ifdef STR_SEQ_CASE_EN
                case_up <= ~cmd_op[0];
                if (str_len != '0) begin
                  state     <= S_CASE;
                  rsp_valid <= 1'b0;
                end
`else
                rsp_err <= 1'b1;
`endif
              end
            endcase
          end
        end
        S_RSP: begin
          rsp_valid <= 1'b0;
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        S_CMP: begin
          if (cur_ch != opd_ch) begin
            rsp_cmp   <= (cur_ch < opd_ch) ? 2'b01 : 2'b10;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end else if (cur + LW'(1) == cmp_min) begin
            rsp_cmp   <= len_order(str_len, clen);
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end else begin
            cur <= cur + LW'(1);
          end
        end
        S_REP: begin
          // Source chars are the untouched prefix of the string, cycled modulo the snapshot length.
          if (str_len == MAXL) begin
            overflow  <= 1'b1;
            rsp_err   <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end else begin
            str_out <= {str_out[SW-9:0], cur_ch};
            str_len <= str_len + LW'(1);
            cur     <= (cur + LW'(1) == rlen) ? '0 : cur + LW'(1);
            if (TW'(str_len) + TW'(1) == rtgt) begin
              rsp_valid <= 1'b1;
              state     <= S_RSP;
            end
          end
        end
`ifdef STR_SEQ_CASE_EN
        S_CASE: begin
          str_out <= put_char(str_out, str_len, cur, conv_case(cur_ch, case_up));
          if (cur + LW'(1) == str_len) begin
            rsp_valid <= 1'b1;
            state     <= S_RSP;
          end else begin
            cur <= cur + LW'(1);
          end
        end
`endif
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_str_seq_engine.sv
// Directed table-driven bench for str_seq_engine plus busy-drop and mid-op reset sequences.
module tb_str_seq_engine;

  localparam int MAX_CHARS = 8;
  localparam int IDXW      = 3;
  localparam int CNTW      = 4;
  localparam int SW        = MAX_CHARS * 8;
  localparam int LW        = IDXW + 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            cmd_valid = 1'b0;
  logic            cmd_ready;
  logic [2:0]      cmd_op = '0;
  logic [IDXW-1:0] cmd_idx = '0;
  logic [7:0]      cmd_char = '0;
  logic [CNTW-1:0] cmd_count = '0;
  logic [SW-1:0]   cmp_str = '0;
  logic [LW-1:0]   cmp_len = '0;
  logic            rsp_valid;
  logic            rsp_err;
  logic [7:0]      rsp_char;
  logic [1:0]      rsp_cmp;
  logic [SW-1:0]   str_out;
  logic [LW-1:0]   str_len;
  logic            overflow;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  str_seq_engine #(.MAX_CHARS(MAX_CHARS), .IDXW(IDXW), .CNTW(CNTW)) dut (
    .clk(clk), .rst_n(rst_n), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_idx(cmd_idx), .cmd_char(cmd_char), .cmd_count(cmd_count),
    .cmp_str(cmp_str), .cmp_len(cmp_len), .rsp_valid(rsp_valid), .rsp_err(rsp_err),
    .rsp_char(rsp_char), .rsp_cmp(rsp_cmp), .str_out(str_out), .str_len(str_len),
    .overflow(overflow)
  );

  typedef struct {
    logic [2:0]      op;
    logic [IDXW-1:0] idx;
    logic [7:0]      ch;
    logic [CNTW-1:0] cnt;
    logic [SW-1:0]   cstr;
    logic [LW-1:0]   clen;
    logic            err;
    logic [7:0]      rchar;
    logic [1:0]      rcmp;
    logic [LW-1:0]   len;
    logic [SW-1:0]   str;
    logic            ovf;
    int              lat;   // 0 = latency not checked
  } vec_t;

  vec_t vq[$];

  function automatic vec_t mk(input int op, input int idx, input int ch, input int cnt,
                              input logic [SW-1:0] cstr, input int clen, input int err,
                              input int rchar, input int rcmp, input int len,
                              input logic [SW-1:0] str, input int ovf, input int lat);
    vec_t v;
    v.op = 3'(op); v.idx = IDXW'(idx); v.ch = 8'(ch); v.cnt = CNTW'(cnt);
    v.cstr = cstr; v.clen = LW'(clen); v.err = err[0]; v.rchar = 8'(rchar);
    v.rcmp = 2'(rcmp); v.len = LW'(len); v.str = str; v.ovf = ovf[0]; v.lat = lat;
    return v;
  endfunction

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input int n);
    int lat;
    @(negedge clk);
    cmd_op = v.op; cmd_idx = v.idx; cmd_char = v.ch; cmd_count = v.cnt;
    cmp_str = v.cstr; cmp_len = v.clen; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d_rsp_valid", n), 64'(rsp_valid), 64'd1);
    check($sformatf("v%0d_err", n), 64'(rsp_err), 64'(v.err));
    check($sformatf("v%0d_len", n), 64'(str_len), 64'(v.len));
    check($sformatf("v%0d_str", n), str_out, v.str);
    check($sformatf("v%0d_ovf", n), 64'(overflow), 64'(v.ovf));
    if (v.op == 3'd3) check($sformatf("v%0d_char", n), 64'(rsp_char), 64'(v.rchar));
    if (v.op == 3'd4) check($sformatf("v%0d_cmp", n), 64'(rsp_cmp), 64'(v.rcmp));
    if (v.lat != 0)   check($sformatf("v%0d_lat", n), 64'(lat), 64'(v.lat));
    @(posedge clk); #1;
    check($sformatf("v%0d_ready", n), 64'(cmd_ready), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    bit seen;

    // op idx ch cnt cstr clen | err rchar rcmp len str ovf lat
    vq.push_back(mk(0, 0, 0,   0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 1));
    vq.push_back(mk(1, 0, "s", 0, 64'h0, 0, 0, 0, 0, 1, "s",   0, 1));
    vq.push_back(mk(1, 0, "=", 0, 64'h0, 0, 0, 0, 0, 2, "s=",  0, 1));
    vq.push_back(mk(1, 0, "a", 0, 64'h0, 0, 0, 0, 0, 3, 64'h00733D61, 0, 1));
    vq.push_back(mk(0, 0, 0,   0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 1));
    vq.push_back(mk(1, 0, "a", 0, 64'h0, 0, 0, 0, 0, 1, "a",   0, 1));
    vq.push_back(mk(4, 0, 0, 0, "b",  1, 0, 0, 1, 1, "a", 0, 2));
    vq.push_back(mk(4, 0, 0, 0, " ",  1, 0, 0, 2, 1, "a", 0, 2));
    vq.push_back(mk(4, 0, 0, 0, "a",  1, 0, 0, 0, 1, "a", 0, 2));
    vq.push_back(mk(4, 0, 0, 0, "ab", 2, 0, 0, 1, 1, "a", 0, 2));
    vq.push_back(mk(4, 0, 0, 0, 64'h0, 0, 0, 0, 2, 1, "a", 0, 1));
    vq.push_back(mk(0, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 1));
    vq.push_back(mk(4, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 1));
    vq.push_back(mk(1, 0, "b", 0, 64'h0, 0, 0, 0, 0, 1, "b",   0, 1));
    vq.push_back(mk(5, 0, 0, 3, 64'h0, 0, 0, 0, 0, 3, "bbb",   0, 0));
    vq.push_back(mk(5, 0, 0, 4, 64'h0, 0, 1, 0, 0, 8, "bbbbbbbb", 1, 0));
    vq.push_back(mk(1, 0, "x", 0, 64'h0, 0, 1, 0, 0, 8, "bbbbbbbb", 1, 1));
    vq.push_back(mk(0, 0, 0,   0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 1));
    vq.push_back(mk(1, 0, "a", 0, 64'h0, 0, 0, 0, 0, 1, "a",       0, 1));
    vq.push_back(mk(1, 0, "s", 0, 64'h0, 0, 0, 0, 0, 2, "as",      0, 1));
    vq.push_back(mk(1, 0, "t", 0, 64'h0, 0, 0, 0, 0, 3, "ast",     0, 1));
    vq.push_back(mk(1, 0, "r", 0, 64'h0, 0, 0, 0, 0, 4, "astr",    0, 1));
    vq.push_back(mk(1, 0, "i", 0, 64'h0, 0, 0, 0, 0, 5, "astri",   0, 1));
    vq.push_back(mk(1, 0, "n", 0, 64'h0, 0, 0, 0, 0, 6, "astrin",  0, 1));
    vq.push_back(mk(1, 0, "g", 0, 64'h0, 0, 0, 0, 0, 7, "astring", 0, 1));
    vq.push_back(mk(3, 1, 0,   0, 64'h0, 0, 0, "s", 0, 7, "astring", 0, 1));
    vq.push_back(mk(2, 0, "0", 0, 64'h0, 0, 0, 0, 0, 7, "0string", 0, 1));
    vq.push_back(mk(2, 3, "3", 0, 64'h0, 0, 0, 0, 0, 7, "0st3ing", 0, 1));
    vq.push_back(mk(2, 7, "z", 0, 64'h0, 0, 1, 0, 0, 7, "0st3ing", 0, 1));
    vq.push_back(mk(2, 2, 0,   0, 64'h0, 0, 1, 0, 0, 7, "0st3ing", 0, 1));
    vq.push_back(mk(3, 7, 0,   0, 64'h0, 0, 1, 0, 0, 7, "0st3ing", 0, 1));
    vq.push_back(mk(3, 6, 0,   0, 64'h0, 0, 0, "g", 0, 7, "0st3ing", 0, 1));
    vq.push_back(mk(4, 0, 0, 0, "0st3ingz", 15, 0, 0, 1, 7, "0st3ing", 0, 8));
    vq.push_back(mk(4, 0, 0, 0, "0st3ing",   7, 0, 0, 0, 7, "0st3ing", 0, 8));
    vq.push_back(mk(4, 0, 0, 0, "0su",       3, 0, 0, 1, 7, "0st3ing", 0, 4));
    vq.push_back(mk(5, 0, 0, 1, 64'h0, 0, 0, 0, 0, 7, "0st3ing", 0, 0));
    vq.push_back(mk(5, 0, 0, 0, 64'h0, 0, 0, 0, 0, 0, 64'h0,     0, 0));
    vq.push_back(mk(1, 0, "a", 0, 64'h0, 0, 0, 0, 0, 1, "a",    0, 1));
    vq.push_back(mk(1, 0, "B", 0, 64'h0, 0, 0, 0, 0, 2, "aB",   0, 1));
    vq.push_back(mk(1, 0, "1", 0, 64'h0, 0, 0, 0, 0, 3, "aB1",  0, 1));
    vq.push_back(mk(1, 0, "z", 0, 64'h0, 0, 0, 0, 0, 4, "aB1z", 0, 1));
`ifdef STR_SEQ_CASE_EN
    vq.push_back(mk(6, 0, 0, 0, 64'h0, 0, 0, 0, 0, 4, "AB1Z", 0, 5));
    vq.push_back(mk(7, 0, 0, 0, 64'h0, 0, 0, 0, 0, 4, "ab1z", 0, 5));
`else
    vq.push_back(mk(6, 0, 0, 0, 64'h0, 0, 1, 0, 0, 4, "aB1z", 0, 1));
    vq.push_back(mk(7, 0, 0, 0, 64'h0, 0, 1, 0, 0, 4, "aB1z", 0, 1));
`endif
    vq.push_back(mk(0, 0, 0,   0, 64'h0, 0, 0, 0, 0, 0, 64'h0, 0, 1));
    vq.push_back(mk(1, 0, "b", 0, 64'h0, 0, 0, 0, 0, 1, "b",   0, 1));

    // Reset state.
    #12;
    check("rst_ready", 64'(cmd_ready), 64'd1);
    check("rst_valid", 64'(rsp_valid), 64'd0);
    check("rst_len",   64'(str_len),   64'd0);
    check("rst_str",   str_out,        64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    foreach (vq[i]) run_vec(vq[i], i);

    // Busy: an APPEND held on cmd_valid during REPLICATE must be dropped.
    @(negedge clk);
    cmd_op = 3'd5; cmd_count = 4'd3; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_op = 3'd1; cmd_char = "z";
    check("busy_ready", 64'(cmd_ready), 64'd0);
    lat = 1;
    while (!rsp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    cmd_valid = 1'b0;
    check("busy_rsp", 64'(rsp_valid), 64'd1);
    check("busy_str", str_out, 64'h0000000000626262);
    repeat (3) @(posedge clk);
    #1;
    check("busy_len_after", 64'(str_len), 64'd3);
    check("busy_no_rsp", 64'(rsp_valid), 64'd0);

    // Reset in the middle of a REPLICATE.
    @(negedge clk);
    cmd_op = 3'd5; cmd_count = 4'd2; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    check("midrep_len", 64'(str_len), 64'd4);
    rst_n = 1'b0;
    #1;
    check("arst_len",   64'(str_len),   64'd0);
    check("arst_str",   str_out,        64'd0);
    check("arst_valid", 64'(rsp_valid), 64'd0);
    check("arst_err",   64'(rsp_err),   64'd0);
    check("arst_char",  64'(rsp_char),  64'd0);
    check("arst_cmp",   64'(rsp_cmp),   64'd0);
    check("arst_ovf",   64'(overflow),  64'd0);
    check("arst_ready", 64'(cmd_ready), 64'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (6) begin
      @(posedge clk); #1;
      seen |= rsp_valid;
    end
    check("arst_no_rsp", 64'(seen), 64'd0);
    check("arst_len_hold", 64'(str_len), 64'd0);
    check("arst_ready_hold", 64'(cmd_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
